// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
//   WORDSIZE / REGADDRSIZE : datapath and register-address widths
//   XZR                    : zero register; writes to it are dropped
//   WBREQ_*                : requester index assignments
//   wrap_idx               : single-step modulo for rotating indices
package regfile_wb_arbiter_pkg;

    localparam int WORDSIZE    = 32;
    localparam int REGADDRSIZE = 5;

    localparam logic [REGADDRSIZE-1:0] XZR = 5'd31;

    localparam int WBREQ_ALU  = 0;
    localparam int WBREQ_MEM  = 1;
    localparam int WBREQ_LINK = 2;

    // idx is always < 2*n at every call site, so one subtraction is enough.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid : request vector
//   ptr   : index with highest priority this cycle (0..NREQ-1)
//   grant : one-hot grant, zero when no request is valid
// Requests are rotated so that ptr lands on bit 0, the lowest set bit is
// picked, and the choice is rotated back to its original index.
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] rot;
    logic            found;
    int              first;

    always_comb begin
        rot   = '0;
        grant = '0;
        found = 1'b0;
        first = 0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = valid[wrap_idx(int'(ptr) + i, NREQ)];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                first = i;
            end
        end
        if (found) begin
            grant[wrap_idx(int'(ptr) + first, NREQ)] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NREQ writeback sources.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : squash the staged write, suppress this cycle's grant
//   req_valid/rd/data     : per-requester write requests (packed slices)
//   req_ready             : one-hot grant; a transfer is valid & ready
//   wr_en/wr_rd/wr_data   : one-cycle staged write to the register file
//   rn, rm                : register-file read addresses this cycle
//   fwd_n, fwd_m          : staged write hits rn / rm, forward wr_data
// Handshake: requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both high; it holds valid/rd/data stable until then.
// The granted write is visible on wr_* in the following cycle.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*REGADDRSIZE-1:0] req_rd,
    input  logic [NREQ*WORDSIZE-1:0]    req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        wr_en,
    output logic [REGADDRSIZE-1:0]      wr_rd,
    output logic [WORDSIZE-1:0]         wr_data,
    input  logic [REGADDRSIZE-1:0]      rn,
    input  logic [REGADDRSIZE-1:0]      rm,
    output logic                        fwd_n,
    output logic                        fwd_m
);

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_next;
    logic [NREQ-1:0]        grant;
    logic                   any_grant;
    logic [REGADDRSIZE-1:0] sel_rd;
    logic [WORDSIZE-1:0]    sel_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grants are withheld during reset and flush, so nothing is accepted
    // that the output stage would then discard.
    assign req_ready = grant & {NREQ{reset_n & ~flush}};
    assign any_grant = |req_ready;

    // Select the winner's payload and the pointer slot just past it.
    // The wrap to 0 is explicit so non-power-of-2 NREQ works.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        ptr_next = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_rd   = req_rd[i*REGADDRSIZE +: REGADDRSIZE];
                sel_data = req_data[i*WORDSIZE +: WORDSIZE];
                ptr_next = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else if (flush) begin
            // wr_rd/wr_data intentionally keep their previous values.
            wr_en <= 1'b0;
        end else if (any_grant) begin
            // An XZR destination still consumes the slot but never writes.
            wr_en   <= (sel_rd != XZR);
            wr_rd   <= sel_rd;
            wr_data <= sel_data;
            ptr     <= ptr_next;
        end else begin
            wr_en <= 1'b0;
        end
    end

    assign fwd_n = wr_en && (wr_rd == rn) && (rn != XZR);
    assign fwd_m = wr_en && (wr_rd == rm) && (rm != XZR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int N = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 flush;
    logic [N-1:0]         req_valid;
    logic [N*5-1:0]       req_rd;
    logic [N*32-1:0]      req_data;
    logic [N-1:0]         req_ready;
    logic                 wr_en;
    logic [4:0]           wr_rd;
    logic [31:0]          wr_data;
    logic [4:0]           rn;
    logic [4:0]           rm;
    logic                 fwd_n;
    logic                 fwd_m;

    regfile_wb_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data),
        .rn        (rn),
        .rm        (rm),
        .fwd_n     (fwd_n),
        .fwd_m     (fwd_m)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    localparam logic [2:0] G_ALU  = 3'b001 << WBREQ_ALU;
    localparam logic [2:0] G_MEM  = 3'b001 << WBREQ_MEM;
    localparam logic [2:0] G_LINK = 3'b001 << WBREQ_LINK;

    localparam logic [31:0] A0 = 32'h0000_00A0;
    localparam logic [31:0] A1 = 32'h0000_00A1;
    localparam logic [31:0] A2 = 32'h0000_00A2;

    localparam logic [14:0] RD_ALL = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] D_ALL  = {A2, A1, A0};
    localparam logic [14:0] RD_B   = {5'd0, 5'd5, 5'd31};
    localparam logic [95:0] D_B    = {32'h0, 32'hDEAD_BEEF, 32'd7};
    localparam logic [14:0] RD_C   = {5'd9, 5'd0, 5'd0};
    localparam logic [95:0] D_C    = {32'h99, 32'h0, 32'h0};
    localparam logic [14:0] RD_D   = {5'd0, 5'd0, 5'd4};
    localparam logic [95:0] D_D    = {32'h0, 32'h0, 32'h44};

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic        flush;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [2:0]  ready;
        logic        en;
        logic        chk_wr;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        fn;
        logic        fm;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d, input logic fl,
        input logic [4:0] a_n, input logic [4:0] a_m, input logic [2:0] rdy, input logic en,
        input logic cw, input logic [4:0] wrd, input logic [31:0] wd, input logic fn, input logic fm);
        vec_t r;
        r.valid = v;   r.rd = rd;    r.data = d;   r.flush = fl;
        r.rn = a_n;    r.rm = a_m;   r.ready = rdy; r.en = en;
        r.chk_wr = cw; r.wrd = wrd;  r.wdata = wd;  r.fn = fn; r.fm = fm;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic [2:0] rdy, input logic en,
                                 input logic cw, input logic [4:0] wrd, input logic [31:0] wd,
                                 input logic fn, input logic fm);
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        if (cw) begin
            chk({tag, ".wr_rd"}, 32'(wr_rd), 32'(wrd));
            chk({tag, ".wr_data"}, wr_data, wd);
        end
        chk({tag, ".fwd_n"}, 32'(fwd_n), 32'(fn));
        chk({tag, ".fwd_m"}, 32'(fwd_m), 32'(fm));
    endtask

    // ---------------- random-phase reference model ----------------
    logic [2:0]  pend;
    logic [4:0]  prd[3];
    logic [31:0] pdata[3];
    int          m_ptr;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //        valid  rd      data   fl rn     rm      ready   en cw wrd    wdata          fn fm
        vecs[0]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd0,  5'd0,  G_ALU,  0, 1, 5'd0,  32'h0,         0, 0);
        vecs[1]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd1,  5'd2,  G_MEM,  1, 1, 5'd1,  A0,            1, 0);
        vecs[2]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd0,  5'd0,  G_LINK, 1, 1, 5'd2,  A1,            0, 0);
        vecs[3]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd0,  5'd0,  G_ALU,  1, 1, 5'd3,  A2,            0, 0);
        vecs[4]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd0,  5'd0,  G_MEM,  1, 1, 5'd1,  A0,            0, 0);
        vecs[5]  = mk(3'b111, RD_ALL, D_ALL, 0, 5'd0,  5'd0,  G_LINK, 1, 1, 5'd2,  A1,            0, 0);
        vecs[6]  = mk(3'b011, RD_B,   D_B,   0, 5'd0,  5'd0,  G_ALU,  1, 1, 5'd3,  A2,            0, 0);
        vecs[7]  = mk(3'b010, RD_B,   D_B,   0, 5'd0,  5'd0,  G_MEM,  0, 0, 5'd0,  32'h0,         0, 0);
        vecs[8]  = mk(3'b000, RD_B,   D_B,   0, 5'd5,  5'd31, 3'b000, 1, 1, 5'd5,  32'hDEAD_BEEF, 1, 0);
        vecs[9]  = mk(3'b100, RD_C,   D_C,   1, 5'd0,  5'd0,  3'b000, 0, 0, 5'd0,  32'h0,         0, 0);
        vecs[10] = mk(3'b100, RD_C,   D_C,   0, 5'd0,  5'd0,  G_LINK, 0, 0, 5'd0,  32'h0,         0, 0);
        vecs[11] = mk(3'b001, RD_D,   D_D,   1, 5'd9,  5'd0,  3'b000, 1, 1, 5'd9,  32'h99,        1, 0);
        vecs[12] = mk(3'b001, RD_D,   D_D,   0, 5'd9,  5'd9,  G_ALU,  0, 1, 5'd9,  32'h99,        0, 0);
        vecs[13] = mk(3'b000, RD_D,   D_D,   0, 5'd4,  5'd31, 3'b000, 1, 1, 5'd4,  32'h44,        1, 0);
        vecs[14] = mk(3'b000, RD_D,   D_D,   0, 5'd4,  5'd4,  3'b000, 0, 0, 5'd0,  32'h0,         0, 0);

        // ---- reset held with every requester asking ----
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 3'b111;
        req_rd    = RD_ALL;
        req_data  = D_ALL;
        rn        = 5'd0;
        rm        = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("in_reset", 3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_rd    = vecs[i].rd;
            req_data  = vecs[i].data;
            flush     = vecs[i].flush;
            rn        = vecs[i].rn;
            rm        = vecs[i].rm;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].ready, vecs[i].en, vecs[i].chk_wr,
                          vecs[i].wrd, vecs[i].wdata, vecs[i].fn, vecs[i].fm);
            @(posedge clk); #1;
        end

        // ---- reset in the middle of a cycle with a write staged ----
        req_valid = 3'b111;
        req_rd    = RD_ALL;
        req_data  = D_ALL;
        rn        = 5'd1;
        rm        = 5'd0;
        @(posedge clk); #2;          // pointer now at index 2 and a write is staged
        chk("pre_reset.wr_en", 32'(wr_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 3'b000, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset.first_grant", 32'(req_ready), 32'(G_ALU));
        @(posedge clk); #1;

        // ---- randomized traffic against the reference model ----
        reset_n   = 1'b0;
        req_valid = '0;
        flush     = 1'b0;
        #1;
        reset_n = 1'b1;
        pend   = '0;
        m_ptr  = 0;
        m_en   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        for (int i = 0; i < 3; i++) begin
            prd[i]   = '0;
            pdata[i] = '0;
        end
        @(posedge clk); #1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            int          g;
            logic [2:0]  exp_ready;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    prd[i]   = ($urandom_range(0, 5) == 0) ? XZR : 5'($urandom_range(0, 30));
                    pdata[i] = $urandom;
                end
            end
            flush     = ($urandom_range(0, 7) == 0);
            rn        = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
            rm        = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
            req_valid = pend;
            req_rd    = {prd[2], prd[1], prd[0]};
            req_data  = {pdata[2], pdata[1], pdata[0]};

            // first pending requester scanning from the pointer, modulo N
            g = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;

            @(negedge clk);
            check_outputs($sformatf("rand%0d", cyc), exp_ready, m_en, m_en, m_rd, m_data,
                          m_en && (m_rd == rn) && (rn != XZR),
                          m_en && (m_rd == rm) && (rm != XZR));

            @(posedge clk);
            if (flush) begin
                m_en = 1'b0;
            end else if (g >= 0) begin
                m_en    = (prd[g] != XZR);
                m_rd    = prd[g];
                m_data  = pdata[g];
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
            end else begin
                m_en = 1'b0;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
